// File: rtl/parking_lot_if.sv
// parking_lot_if: board-level buttons, sensors and display/indicator outputs of the parking-lot controller.
`timescale 1ns/1ps
interface parking_lot_if;
    logic        pow;
    logic        pay;
    logic [7:0]  swt;
    logic        buz;
    logic [7:0]  row;
    logic [7:0]  col_r;
    logic [7:0]  col_g;
    logic [7:0]  dis;
    logic [7:0]  seg;
    logic [15:0] led;
    modport master (output pow, pay, swt, input buz, row, col_r, col_g, dis, seg, led);
    modport slave (input pow, pay, swt, output buz, row, col_r, col_g, dis, seg, led);
endinterface

// File: rtl/parking_lot.sv
// parking_lot: 8-space parking controller with fee timers, payment alarm, dot matrix and 7-seg scan.
// Optional buzzer beeping while payment is pending is enabled by defining PARKING_BUZZER_EN.
`timescale 1ns/1ps
module parking_lot #(
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 10_000
) (
    input logic clk,
    input logic rst,
    parking_lot_if.slave bus
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    typedef enum logic {OFF, ON} state_t;
    state_t state, state_nx;
    logic [7:0] swt_s1, swt_s2, swt_d, dep, arr;
    logic [1:0] pow_s, pay_s;
    logic pow_d, pay_d, pow_e, pay_e, clr, tick, on;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] scan_cnt;
    logic [2:0] idx;
    logic [7:0][7:0] timer;
    logic [9:0] due, due_nx;
    logic [11:0] fees, sum;
    logic pending;
    logic [3:0] digit;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            swt_s1 <= '0;
            swt_s2 <= '0;
            swt_d  <= '0;
            pow_s  <= '0;
            pow_d  <= 1'b0;
            pay_s  <= '0;
            pay_d  <= 1'b0;
        end else begin
            swt_s1 <= bus.swt;
            swt_s2 <= swt_s1;
            swt_d  <= swt_s2;
            pow_s  <= {pow_s[0], bus.pow};
            pow_d  <= pow_s[1];
            pay_s  <= {pay_s[0], bus.pay};
            pay_d  <= pay_s[1];
        end
    assign pow_e = pow_s[1] & ~pow_d;
    assign pay_e = pay_s[1] & ~pay_d;
    assign tick  = tick_cnt == TICK_MAX;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            tick_cnt <= '0;
            scan_cnt <= '0;
            idx      <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            scan_cnt <= scan_cnt == SCAN_MAX ? '0 : scan_cnt + 1'b1;
            idx      <= scan_cnt == SCAN_MAX ? idx + 1'b1 : idx;
        end
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= OFF;
        else state <= state_nx;
    always_comb state_nx = pow_e ? (state == ON ? OFF : ON) : state;
    // Power off (or the cycle that turns it off) wipes all billing state.
    assign clr = (state == OFF) | pow_e;
    assign dep = swt_d & ~swt_s2;
    assign arr = ~swt_d & swt_s2;
    always_comb begin
        fees = '0;
        for (int i = 0; i < 8; i++) fees += dep[i] ? 12'(timer[i]) : 12'd0;
    end
    // A pay edge in the same cycle as a departure zeroes the old due before adding new fees.
    assign sum    = ((pay_e & pending) ? 12'd0 : 12'(due)) + fees;
    assign due_nx = sum > 12'd999 ? 10'd999 : sum[9:0];
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            timer   <= '0;
            due     <= '0;
            pending <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++)
                timer[i] <= (clr | dep[i] | arr[i]) ? 8'd0 :
                            (tick & swt_s2[i] & (timer[i] != 8'hFF)) ? timer[i] + 1'b1 : timer[i];
            due     <= clr ? 10'd0 : due_nx;
            pending <= clr ? 1'b0 : (|dep | (pending & ~pay_e));
        end
    always_ff @(posedge clk or negedge rst)
        if (!rst) bus.led <= '0;
        else bus.led <= state == ON ? {1'b1, &swt_s2, pending, 5'b0, swt_s2} : 16'h0;
`ifdef PARKING_BUZZER_EN
    logic beep;
    always_ff @(posedge clk or negedge rst)
        if (!rst) beep <= 1'b0;
        else beep <= (clr | (|dep & ~pending)) ? 1'b0 : beep ^ tick;
    assign bus.buz = on & pending & beep;
`else
    assign bus.buz = 1'b0;
`endif
    always_comb begin
        on    = state == ON;
        digit = idx == 3'd7 ? 4'(4'd8 - 4'($countones(swt_s2))) :
                idx == 3'd2 ? 4'(due / 10'd100) :
                idx == 3'd1 ? 4'((due / 10'd10) % 10'd10) : 4'(due % 10'd10);
        bus.row   = on ? 8'd1 << idx : 8'h00;
        bus.col_r = (on & ~swt_s2[idx]) ? 8'hFF : on ? 8'h00 : 8'hFF;
        bus.col_g = (on & ~swt_s2[idx]) ? 8'h00 : 8'hFF;
        bus.dis   = on ? ~(8'd1 << idx) : 8'hFF;
        bus.seg   = (on & (idx < 3'd3 | idx == 3'd7)) ? {1'b1, ~SEG[digit]} : 8'hFF;
    end
endmodule

// File: tb/tb_parking_lot.sv
// tb_parking_lot: directed plus randomized stimulus checked against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_parking_lot;
    localparam int TICK = 10, SCAN = 4;
    logic clk = 1'b0, rst = 1'b0;
    parking_lot_if bus();
    parking_lot #(.TICK_DIV(TICK), .SCAN_DIV(SCAN)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #1 clk = ~clk;
    int checks = 0, errors = 0;
    logic [7:0] segl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [7:0] hs [4] = '{default: 8'h00};
    bit hp [4] = '{default: 1'b0};
    bit hy [4] = '{default: 1'b0};
    int tmr [8] = '{default: 0};
    int due_m = 0;
    int cyc = 0;
    bit pend_m = 0, on_m = 0, beep_m = 0;
    logic [15:0] led_m = 16'h0;
    // Reference model: inputs seen two cycles late through the synchronisers.
    always @(posedge clk or negedge rst) begin
        bit tick, pe, ye, any_dep;
        int fees, base;
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin hs[k] = 0; hp[k] = 0; hy[k] = 0; end
            for (int i = 0; i < 8; i++) tmr[i] = 0;
            due_m = 0; cyc = 0; pend_m = 0; on_m = 0; beep_m = 0; led_m = 0;
        end else begin
            tick = (cyc % TICK) == TICK - 1;
            cyc++;
            for (int k = 3; k > 0; k--) begin hs[k] = hs[k-1]; hp[k] = hp[k-1]; hy[k] = hy[k-1]; end
            hs[0] = bus.swt; hp[0] = bus.pow; hy[0] = bus.pay;
            led_m = on_m ? {1'b1, &hs[2], pend_m, 5'b0, hs[2]} : 16'h0;
            pe = hp[2] && !hp[3];
            ye = hy[2] && !hy[3];
            if (!on_m || pe) begin
                for (int i = 0; i < 8; i++) tmr[i] = 0;
                due_m = 0; pend_m = 0; beep_m = 0;
            end else begin
                fees = 0; any_dep = 0;
                for (int i = 0; i < 8; i++)
                    if (hs[3][i] && !hs[2][i]) begin fees += tmr[i]; tmr[i] = 0; any_dep = 1; end
                    else if (!hs[3][i] && hs[2][i]) tmr[i] = 0;
                    else if (tick && hs[2][i] && tmr[i] < 255) tmr[i]++;
                base = (ye && pend_m) ? 0 : due_m;
                if (any_dep) begin
                    due_m = base + fees > 999 ? 999 : base + fees;
                    beep_m = pend_m ? beep_m ^ tick : 1'b0;
                    pend_m = 1;
                end else begin
                    due_m = base;
                    if (ye) pend_m = 0;
                    beep_m = beep_m ^ tick;
                end
            end
            on_m = on_m ^ pe;
        end
    end
    task automatic chk(input string tag, input string what, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, got, exp);
        end
    endtask
    task automatic check_all(input string tag);
        int d, v;
        logic [7:0] s2, e_row, e_cr, e_cg, e_dis, e_seg;
        logic e_buz;
        d = (cyc / SCAN) % 8;
        s2 = hs[1];
        v = d == 7 ? 8 - $countones(s2) : d == 2 ? due_m / 100 : d == 1 ? (due_m / 10) % 10 : due_m % 10;
        e_row = on_m ? 8'(1 << d) : 8'h00;
        e_cr  = (on_m && s2[d]) ? 8'h00 : 8'hFF;
        e_cg  = (on_m && !s2[d]) ? 8'h00 : 8'hFF;
        e_dis = on_m ? ~8'(1 << d) : 8'hFF;
        e_seg = (on_m && (d <= 2 || d == 7)) ? segl[v] : 8'hFF;
`ifdef PARKING_BUZZER_EN
        e_buz = on_m & pend_m & beep_m;
`else
        e_buz = 1'b0;
`endif
        chk(tag, "buz", 16'(bus.buz), 16'(e_buz));
        chk(tag, "row", 16'(bus.row), 16'(e_row));
        chk(tag, "col_r", 16'(bus.col_r), 16'(e_cr));
        chk(tag, "col_g", 16'(bus.col_g), 16'(e_cg));
        chk(tag, "dis", 16'(bus.dis), 16'(e_dis));
        chk(tag, "seg", 16'(bus.seg), 16'(e_seg));
        chk(tag, "led", bus.led, led_m);
    endtask
    task automatic run(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            check_all(tag);
        end
    endtask
    task automatic pulse_pow(input string tag);
        bus.pow = 1'b1; run(3, tag); bus.pow = 1'b0;
    endtask
    task automatic pulse_pay(input string tag);
        bus.pay = 1'b1; run(2, tag); bus.pay = 1'b0;
    endtask
    initial begin
        int r;
        bus.pow = 1'b0; bus.pay = 1'b0; bus.swt = 8'h00;
        run(3, "in_reset");
        rst = 1'b1;
        run(1000, "idle_off");
        pulse_pow("pow_on");
        run(40, "empty_on");
        bus.swt = 8'h01;
        run(100, "stay");
        bus.swt = 8'h00;
        run(40, "departed");
        pulse_pay("pay1");
        run(20, "paid");
        pulse_pay("pay2");
        run(20, "pay_ignored");
        bus.swt = 8'hFF;
        run(3010, "full");
        bus.swt = 8'h00;
        run(40, "saturated");
        pulse_pow("pow_off");
        run(40, "off_pending");
        pulse_pow("pow_on2");
        run(40, "on_again");
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 99);
            if (r < 70) bus.swt = 8'($urandom);
            else if (r < 96) pulse_pay("rnd_pay");
            else pulse_pow("rnd_pow");
            run($urandom_range(5, 60), "random");
        end
        @(negedge clk);
        #0.5 rst = 1'b0;
        #0.2 check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        run(50, "after_rst");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
